// File: rtl/vga_text_pkg.sv
// Shared text-mode geometry defaults and
// address/scanline widths for the VGA text path.
package vga_text_pkg;
  localparam int COLS_D         = 80;
  localparam int ROWS_D         = 25;
  localparam int CHAR_W_D       = 8;
  localparam int LINE_REPEAT_D  = 2;
  localparam int BLINK_FRAMES_D = 16;
  localparam int ADDR_W         = 15;
  localparam int SCAN_W         = 3;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SCAN_W-1:0] scan_t;
endpackage

// File: rtl/cursor_blink.sv
// Frame counter driving the cursor blink phase.
// Phase starts visible and toggles every BLINK_FRAMES frames.
module cursor_blink
  import vga_text_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_FRAMES_D
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_start,
  output logic blink_phase
);
  localparam int BW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (cnt == BW'(BLINK_FRAMES - 1)) begin
        cnt         <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_cursor_overlay.sv
// Text cursor overlay: tracks cell/scanline from
// pixel and line strobes, emits registered cursor flag.
module vga_cursor_overlay
  import vga_text_pkg::*;
#(
  parameter int COLS         = COLS_D,
  parameter int ROWS         = ROWS_D,
  parameter int CHAR_W       = CHAR_W_D,
  parameter int LINE_REPEAT  = LINE_REPEAT_D,
  parameter int BLINK_FRAMES = BLINK_FRAMES_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cursor_enabled,
  input  logic              graphics_enabled,
  input  logic [ADDR_W-1:0] cursor_pos,
  input  logic [SCAN_W-1:0] cursor_scan_start,
  input  logic [SCAN_W-1:0] cursor_scan_end,
  input  logic              pix_valid,
  input  logic              line_end,
  input  logic              frame_start,
  output logic              cursor_pixel,
  output logic [ADDR_W-1:0] char_addr,
  output logic [SCAN_W-1:0] scanline,
  output logic              blink_phase
);
  localparam int SXW =
    (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam int RPW =
    (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam addr_t CELLS = ADDR_W'(COLS * ROWS);

  logic [SXW-1:0] sub_x;
  logic [CW-1:0]  col;
  logic [RPW-1:0] rep;
  scan_t          scan;
  logic [RW-1:0]  row;
  addr_t          row_base;
  addr_t          cell_addr;
  logic           armed;
  logic           in_range;
  logic           hit;

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_x    <= '0;
      col      <= '0;
      rep      <= '0;
      scan     <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (frame_start) begin
      sub_x    <= '0;
      col      <= '0;
      rep      <= '0;
      scan     <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (line_end) begin
      sub_x <= '0;
      col   <= '0;
      if (rep == RPW'(LINE_REPEAT - 1)) begin
        rep <= '0;
        if (scan == '1) begin
          scan <= '0;
          // row_base only advances with row so it
          // never runs past the last real row
          if (row != RW'(ROWS)) begin
            row      <= row + 1'b1;
            row_base <= row_base + ADDR_W'(COLS);
          end
        end else begin
          scan <= scan + 1'b1;
        end
      end else begin
        rep <= rep + 1'b1;
      end
    end else if (pix_valid) begin
      if (sub_x == SXW'(CHAR_W - 1)) begin
        sub_x <= '0;
        if (col != CW'(COLS))
          col <= col + 1'b1;
      end else begin
        sub_x <= sub_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      armed <= 1'b0;
    else if (frame_start)
      armed <= 1'b1;
  end

  assign cell_addr = row_base + ADDR_W'(col);

  always_comb begin
    in_range = 1'b0;
    hit      = 1'b0;
    if (cursor_scan_start <= cursor_scan_end)
      in_range = (scan >= cursor_scan_start) &&
                 (scan <= cursor_scan_end);
    else
      in_range = (scan >= cursor_scan_start) ||
                 (scan <= cursor_scan_end);
    hit = cursor_enabled && !graphics_enabled &&
          blink_phase && in_range &&
          (col < CW'(COLS)) && (row < RW'(ROWS)) &&
          (cursor_pos < CELLS) &&
          (cell_addr == cursor_pos);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cursor_pixel <= 1'b0;
      char_addr    <= '0;
      scanline     <= '0;
    end else if (pix_valid && armed) begin
      cursor_pixel <= hit;
      char_addr    <= cell_addr;
      scanline     <= scan;
    end else begin
      cursor_pixel <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Directed scoreboard bench for vga_cursor_overlay
// with default 80x25 geometry.
module tb_vga_cursor_overlay;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cursor_enabled = 1'b1;
  logic        graphics_enabled = 1'b0;
  logic [14:0] cursor_pos = '0;
  logic [2:0]  cursor_scan_start = 3'd6;
  logic [2:0]  cursor_scan_end = 3'd7;
  logic        pix_valid = 1'b0;
  logic        line_end = 1'b0;
  logic        frame_start = 1'b0;
  logic        cursor_pixel;
  logic [14:0] char_addr;
  logic [2:0]  scanline;
  logic        blink_phase;

  typedef struct {
    logic [14:0] a;
    logic [2:0]  s;
    logic        p;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int hits = 0;
  int x = 0;
  int y = 0;
  logic armed = 1'b0;
  logic [14:0] held_a = '0;
  logic [2:0]  held_s = '0;
  int m_cnt = 0;
  logic m_bp = 1'b1;

  vga_cursor_overlay dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cursor_enabled   (cursor_enabled),
    .graphics_enabled (graphics_enabled),
    .cursor_pos       (cursor_pos),
    .cursor_scan_start(cursor_scan_start),
    .cursor_scan_end  (cursor_scan_end),
    .pix_valid        (pix_valid),
    .line_end         (line_end),
    .frame_start      (frame_start),
    .cursor_pixel     (cursor_pixel),
    .char_addr        (char_addr),
    .scanline         (scanline),
    .blink_phase      (blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int xx,
                                 input int yy);
    exp_t e;
    int c, r, sc, ad;
    logic inr;
    c  = xx / 8;
    if (c > 80) c = 80;
    r  = yy / 16;
    if (r > 25) r = 25;
    sc = (yy / 2) % 8;
    ad = r * 80 + c;
    if (cursor_scan_start <= cursor_scan_end)
      inr = (sc >= int'(cursor_scan_start)) &&
            (sc <= int'(cursor_scan_end));
    else
      inr = (sc >= int'(cursor_scan_start)) ||
            (sc <= int'(cursor_scan_end));
    e.a = 15'(ad);
    e.s = 3'(sc);
    e.p = cursor_enabled && !graphics_enabled &&
          m_bp && inr && c < 80 && r < 25 &&
          int'(cursor_pos) < 2000 &&
          ad == int'(cursor_pos);
    return e;
  endfunction

  task automatic cyc(input logic pv,
                     input logic le,
                     input logic fs);
    exp_t e;
    @(negedge clk);
    pix_valid   = pv;
    line_end    = le;
    frame_start = fs;
    if (pv) begin
      if (armed) begin
        e = model(x, y);
        held_a = e.a;
        held_s = e.s;
      end else begin
        e.a = held_a;
        e.s = held_s;
        e.p = 1'b0;
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (pv) begin
      e = q.pop_front();
      chk("pix_addr", 32'(char_addr), 32'(e.a));
      chk("pix_scan", 32'(scanline), 32'(e.s));
      chk("pix_cur", 32'(cursor_pixel), 32'(e.p));
      if (cursor_pixel === 1'b1) hits++;
    end else begin
      chk("idle_cur", 32'(cursor_pixel), 32'd0);
      chk("idle_addr", 32'(char_addr), 32'(held_a));
      chk("idle_scan", 32'(scanline), 32'(held_s));
    end
    if (fs) begin
      x = 0;
      y = 0;
      armed = 1'b1;
      if (m_cnt == 15) begin
        m_cnt = 0;
        m_bp  = ~m_bp;
      end else begin
        m_cnt++;
      end
      chk("blink", 32'(blink_phase), 32'(m_bp));
    end else if (le) begin
      x = 0;
      y++;
    end else if (pv) begin
      x++;
    end
  endtask

  task automatic line(input int npix);
    for (int i = 0; i < npix; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
  endtask

  task automatic frame(input int lo, input int hi);
    cyc(0, 0, 1);
    hits = 0;
    for (int yy = 0; yy <= hi; yy++)
      line((yy >= lo) ? 640 : 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cur", 32'(cursor_pixel), 32'd0);
    chk("rst_addr", 32'(char_addr), 32'd0);
    chk("rst_scan", 32'(scanline), 32'd0);
    chk("rst_blink", 32'(blink_phase), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    frame(0, 0);
    chk("line0_hits", 32'(hits), 32'd0);

    cursor_pos = 15'h00A5;
    frame(32, 48);
    chk("a5_hits", 32'(hits), 32'd32);

    cursor_scan_start = 3'd6;
    cursor_scan_end   = 3'd1;
    frame(32, 47);
    chk("split_hits", 32'(hits), 32'd64);
    cursor_scan_end   = 3'd7;

    repeat (12) cyc(0, 0, 1);
    chk("blink_15", 32'(blink_phase), 32'd1);
    cyc(0, 0, 1);
    chk("blink_16", 32'(blink_phase), 32'd0);
    frame(44, 47);
    chk("off_hits", 32'(hits), 32'd0);
    repeat (14) cyc(0, 0, 1);
    chk("blink_31", 32'(blink_phase), 32'd0);
    frame(44, 47);
    chk("blink_32", 32'(blink_phase), 32'd1);
    chk("back_hits", 32'(hits), 32'd32);

    graphics_enabled = 1'b1;
    frame(44, 47);
    chk("gfx_hits", 32'(hits), 32'd0);
    graphics_enabled = 1'b0;
    cursor_pos = 15'd2000;
    frame(44, 47);
    chk("pos2000_hits", 32'(hits), 32'd0);
    cursor_pos = 15'h00A5;
    cursor_enabled = 1'b0;
    frame(44, 47);
    chk("dis_hits", 32'(hits), 32'd0);
    cursor_enabled = 1'b1;

    frame(0, 19);
    for (int i = 0; i < 100; i++) cyc(1, 0, 0);
    cyc(0, 1, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    chk("fsle_addr", 32'(char_addr), 32'd1);

    frame(0, 43);
    for (int i = 0; i < 44; i++) cyc(1, 0, 0);
    chk("pre_rst_cur", 32'(cursor_pixel), 32'd1);
    #3;
    reset_n   = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("mid_rst_cur", 32'(cursor_pixel), 32'd0);
    chk("mid_rst_addr", 32'(char_addr), 32'd0);
    chk("mid_rst_scan", 32'(scanline), 32'd0);
    chk("mid_rst_blink", 32'(blink_phase), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    armed  = 1'b0;
    held_a = '0;
    held_s = '0;
    m_cnt  = 0;
    m_bp   = 1'b1;
    x = 0;
    y = 0;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    frame(0, 0);
    chk("post_rst_hits", 32'(hits), 32'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/vga_cursor_overlay.md
# vga_cursor_overlay

Text-mode cursor overlay generator in the VGA pixel-clock domain, directly downstream of the VGA register block. Consumes the already-synchronised cursor position, scan start/end, cursor-enable and graphics-enable controls, tracks the current character cell and scanline from pixel and line strobes, and produces a registered per-pixel cursor flag. Also handles the cursor blink and exports the current character address for the glyph fetch path.

## Interface
Parameters:
- COLS, 80, character columns per row
- ROWS, 25, character rows per frame
- CHAR_W, 8, pixels per character cell
- LINE_REPEAT, 2, physical lines per cell scanline (line doubling)
- BLINK_FRAMES, 16, frames per blink half-period

Ports:
- clk  in  1  VGA pixel clock
- reset_n  in  1  asynchronous, active-low reset
- cursor_enabled  in  1  cursor shown when 1
- graphics_enabled  in  1  graphics mode; cursor suppressed when 1
- cursor_pos  in  15  linear cell address row*COLS+col
- cursor_scan_start  in  3  first cursor scanline within cell
- cursor_scan_end  in  3  last cursor scanline within cell
- pix_valid  in  1  one active-region pixel this cycle
- line_end  in  1  single-cycle pulse after the last active pixel of a line
- frame_start  in  1  single-cycle pulse before the first active line
- cursor_pixel  out  1  current pixel lies inside a visible cursor
- char_addr  out  15  cell address of the current pixel
- scanline  out  3  cell scanline of the current pixel
- blink_phase  out  1  blink state; cursor visible when 1

## Operation
- Position state: sub_x (0..CHAR_W-1), col (0..COLS), rep (0..LINE_REPEAT-1), scan (0..7), row (0..ROWS), row_base (15 bits, row*COLS kept incrementally; no multiplier).
- pix_valid: sub_x++; on wrap, sub_x=0, col++ (col saturates at COLS).
- line_end: sub_x=0, col=0, rep++; on rep wrap, rep=0, scan++; on scan wrap from 7, scan=0, row++ (saturating at ROWS), row_base+=COLS.
- frame_start: all position state cleared to 0.
- cell_addr = row_base + col, 15-bit unsigned, no truncation possible for legal parameters.
- Hit: cursor_enabled & ~graphics_enabled & blink_phase & col<COLS & row<ROWS & cell_addr==cursor_pos & scan_in_range.
- scan_in_range: start<=end -> start<=scan<=end; start>end -> scan>=start | scan<=end (split cursor).
- cursor_pos >= COLS*ROWS never matches.
- Blink: frame counter counts frame_start pulses 0..BLINK_FRAMES-1; on wrap, blink_phase toggles.

## Timing
- Reset values: cursor_pixel=0, char_addr=0, scanline=0, blink_phase=1, all counters 0.
- Latency: cursor_pixel, char_addr and scanline are registered and describe the pixel presented with pix_valid one cycle earlier; all three hold their values when pix_valid=0, except that cursor_pixel is cleared.
- Priority within a cycle: the pix_valid pixel is evaluated at its pre-update position. frame_start overrides line_end, and both override the pix_valid increment.
- Control inputs are sampled every cycle. Changing them mid-line takes effect at the next pixel; no shadowing.
- Deasserting reset_n mid-frame: outputs are held at their reset values until the first frame_start; the pixel count restarts from cell 0 at that point.

## Structure
- Package vga_text_pkg: default COLS/ROWS/CHAR_W/LINE_REPEAT/BLINK_FRAMES, the cell-address width constant (15), and the scanline width constant (3).
- Sub-module cursor_blink: frame counter plus blink_phase toggle; inputs clk, reset_n, frame_start; output blink_phase.
- The rest stays in one module: position counters, address accumulator, range compare and output register.

## Test plan
- Reset, then frame_start and one full line of 640 pix_valid pulses -> char_addr steps 0..79, changing every 8 pixels; cursor_pixel=0 throughout because blink_phase=1 and cursor_pos=0 with scan 6..7 only.
- cursor_pos=0x00A5 (row 2, col 5), scan 6..7 -> cursor_pixel=1 on exactly 8 pixels × 4 physical lines (lines 44..47); 0 everywhere else in the frame.
- Split cursor, start=6, end=1 -> for the cursor cell, cursor_pixel=1 on scanlines 0, 1, 6 and 7 and 0 on scanlines 2..5.
- 16 frame_start pulses -> blink_phase toggles 1->0 on the 16th pulse, and the cursor at the previous position disappears for the next 16 frames.
- graphics_enabled=1, or cursor_pos=2000, or cursor_enabled=0 -> cursor_pixel stays 0 for a whole frame while char_addr still counts normally.
- frame_start coincident with line_end mid-frame -> next char_addr=0 and scanline=0; reset_n pulsed low mid-line -> outputs drop to reset values asynchronously.
